// File: rtl/fixp_block_presum.sv
// Block pre-summer ahead of the fixed-to-double converter: adds up to cfg_len signed
// Q32.32 samples per block and emits one saturated sum beat per block.
//
// state | meaning
// IDLE  | no beats accepted yet in the current block
// ACC   | block open, accumulating until the closing beat
module fixp_block_presum #(
    parameter int DATA_W  = 64,
    parameter int CNT_W   = 16,
    parameter int GUARD_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tuser,
    output logic [CNT_W-1:0]  m_tcount
);

    localparam int ACC_W = DATA_W + GUARD_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic                m_tuser_q, m_tuser_d;
    logic [CNT_W-1:0]    m_tcount_q, m_tcount_d;

    logic                s_fire;
    logic                m_fire;
    logic                closing;
    logic                emit;
    logic [CNT_W-1:0]    len_eff;
    logic [CNT_W-1:0]    len_cur;
    logic [ACC_W-1:0]    acc_base;
    logic [CNT_W-1:0]    cnt_base;
    logic [ACC_W-1:0]    acc_sum;
    logic [CNT_W-1:0]    cnt_sum;
    logic [GUARD_W:0]    acc_top;
    logic                ovf;
    logic [DATA_W-1:0]   sat_val;

    assign s_tready = ~(m_tvalid_q & ~m_tready);
    assign s_fire   = s_tvalid & s_tready;
    assign m_fire   = m_tvalid_q & m_tready;

    // A zero length would never close a block, so it is promoted to one.
    assign len_eff  = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
    assign len_cur  = (state_q == IDLE) ? len_eff : len_q;
    assign acc_base = (state_q == IDLE) ? '0 : acc_q;
    assign cnt_base = (state_q == IDLE) ? '0 : cnt_q;

    assign acc_sum  = acc_base + {{GUARD_W{s_tdata[DATA_W-1]}}, s_tdata};
    assign cnt_sum  = cnt_base + CNT_W'(1);
    assign closing  = (cnt_sum == len_cur) | s_tlast;
    assign emit     = s_fire & closing;

    // Result fits in DATA_W only when all bits above the DATA_W sign bit match it.
    assign acc_top  = acc_sum[ACC_W-1:DATA_W-1];
    assign ovf      = ~((&acc_top) | ~(|acc_top));
    assign sat_val  = acc_sum[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= CNT_W'(1);
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tuser_q  <= 1'b0;
            m_tcount_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tuser_q  <= m_tuser_d;
            m_tcount_q <= m_tcount_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (s_fire) begin
            state_d = closing ? IDLE : ACC;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tuser_d  = m_tuser_q;
        m_tcount_d = m_tcount_q;

        if (m_fire) begin
            m_tvalid_d = 1'b0;
        end

        if (s_fire) begin
            if (state_q == IDLE) begin
                len_d = len_eff;
            end
            if (closing) begin
                acc_d      = '0;
                cnt_d      = '0;
                m_tvalid_d = 1'b1;
                m_tdata_d  = ovf ? sat_val : acc_sum[DATA_W-1:0];
                m_tuser_d  = ovf;
                m_tcount_d = cnt_sum;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_sum;
            end
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tuser  = m_tuser_q;
    assign m_tcount = m_tcount_q;

    logic unused_emit;
    assign unused_emit = emit;

endmodule
